cmp_pipe: RTL
=============

// Module: cmp_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined integer comparator for branch/set-compare resolution in the EXE path.
//  Carry chain split at SPLIT: stage 1 resolves the low slice, stage 2 the high slice and the final result.
//  Handles the six compare ops (signed/unsigned) with a valid/ready handshake, flush and result tag.
// PARAMETERS
//  WIDTH  32  operand width, >= 2
//  SPLIT  16  low-slice width resolved in stage 1; legal range 1..WIDTH-1
//  TAG_W  5   sideband tag width (e.g. dest reg / ROB id), passed through unchanged
// PORTS
//  clk        in   1       clock; single clock domain
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       kill all in-flight ops this cycle
//  in_valid   in   1       operand beat valid
//  in_ready   out  1       block can accept a beat this cycle
//  in_src1    in   WIDTH   operand A
//  in_src2    in   WIDTH   operand B (raw; inverted internally)
//  in_op      in   3       compare op, encodings below
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_res    out  1       compare result
//  out_tag    out  TAG_W   tag of the result
//  out_sel    out  WIDTH   (CMP_MINMAX_EN only) min/max result
// BEHAVIOUR
//  Ops: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU, 110 MIN, 111 MAX.
//   MIN/MAX: signed; out_res = (A<B). Without the macro: out_res=0 for 110/111.
//  Arithmetic: sum = A + ~B + 1, carry chained lo->hi; lt_s = (A[W-1]&~B[W-1]) | (~(A[W-1]^B[W-1]) & sum[W-1]);
//   lt_u = ~cout; eq = eq_lo & eq_hi (bitwise XNOR reductions per slice); GE/GEU/NE are complements.
//  Stage 1 register: s1_valid, c_lo, eq_lo, A/B high slices, sign bits, op, tag (+ full A,B with macro).
//  Stage 2 register: out_valid, out_res, out_tag (+ out_sel).
//  Handshake: s2_ready = ~out_valid | out_ready; in_ready = ~s1_valid | s2_ready (combinational, no skid).
//   Accept on in_valid & in_ready; advance s1->s2 on s1_valid & s2_ready; retire on out_valid & out_ready.
//  Latency: 2 cycles accept->out_valid when unstalled; throughput 1 op/cycle.
//  Stall: out_valid & ~out_ready holds out_* stable; stage 1 holds if occupied; no beat lost or duplicated.
//  Flush: next cycle s1_valid=0, out_valid=0; beat offered during flush is dropped; in_ready unaffected.
//  Flush and reset mid-op: all in-flight ops discarded, no partial result emitted.
//  Reset values: out_valid=0, out_res=0, out_tag=0, out_sel=0, s1_valid=0; in_ready=1 one cycle after reset.
//  Boundary: SPLIT=1 and SPLIT=WIDTH-1 must be correct; A==B gives EQ=1, LT/LTU=0;
//   A=MIN_INT, B=MAX_INT: LT=1, LTU=0.
// CONFIGURATION
//  CMP_MINMAX_EN defined: ops 110/111 drive out_sel = MIN/MAX(A,B) signed, stage 1 carries full operands.
//  Not defined: out_sel port absent, no full-operand storage; 110/111 give out_res=0, pipeline unchanged.
// STRUCTURE
//  Package cmp_pkg: op encoding constants (CMP_EQ..CMP_MAX), op width 3.
//  Sub-module cmp_slice (parametrised width): slice add with carry in/out, slice equality; one instance per stage.
// TESTING
//  Reset, then A=5,B=7 op LT tag=3, out_ready=1 -> out_valid 2 cycles later, out_res=1, out_tag=3.
//  A=32'h8000_0000, B=32'h7FFF_FFFF: LT -> 1, LTU -> 0, GEU -> 1; A=B=32'hDEAD_BEEF: EQ=1, NE=0, GE=1.
//  Back-to-back 8 ops, out_ready low cycles 3-5 -> in_ready drops once both stages full; results in order.
//  flush while 2 ops in flight plus new beat -> next cycle out_valid=0; none of those 3 tags ever appear.
//  SPLIT=1 and SPLIT=31 builds, random 10k ops vs reference model -> zero mismatches.
//  CMP_MINMAX_EN: A=-3,B=2 op MIN -> out_sel=32'hFFFF_FFFD, MAX -> 2; macro off -> out_res=0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined comparator: op width and op encodings.
package cmp_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b010,
        CMP_GE  = 3'b011,
        CMP_LTU = 3'b100,
        CMP_GEU = 3'b101,
        CMP_MIN = 3'b110,
        CMP_MAX = 3'b111
    } cmp_op_e;

endpackage

// File: rtl/cmp_slice.sv
// One slice of the A + ~B + cin subtract chain: ripple carry out plus slice equality.
module cmp_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         cout,
    output logic         eq
);

    // Only the carry leaves the slice, so it is rippled bit by bit instead of forming the sum.
    always_comb begin
        cout = cin;
        for (int i = 0; i < W; i++) begin
            cout = (a[i] & ~b[i]) | (cout & (a[i] | ~b[i]));
        end
    end

    assign eq = &(a ~^ b);

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator: low carry slice in stage 1, high slice and result in stage 2.
// Optional MIN/MAX operand select is built when CMP_MINMAX_EN is defined.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_res,
    output logic [TAG_W-1:0] out_tag
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] out_sel
`endif
);

    localparam int HI_W = WIDTH - SPLIT;

    logic             s1_valid;
    logic             s1_c_lo;
    logic             s1_eq_lo;
    logic [HI_W-1:0]  s1_a_hi;
    logic [HI_W-1:0]  s1_b_hi;
    cmp_op_e          s1_op;
    logic [TAG_W-1:0] s1_tag;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] sel_nxt;
`endif

    logic c_lo, eq_lo, c_hi, eq_hi;
    logic s2_ready;
    logic sign_a, sign_b;
    logic eq, lt_s, lt_u;
    logic res_nxt;

    assign s2_ready = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_ready;

    cmp_slice #(.W(SPLIT)) u_lo (
        .a    (in_src1[SPLIT-1:0]),
        .b    (in_src2[SPLIT-1:0]),
        .cin  (1'b1),
        .cout (c_lo),
        .eq   (eq_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_c_lo  <= 1'b0;
            s1_eq_lo <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
            s1_op    <= CMP_EQ;
            s1_tag   <= '0;
`ifdef CMP_MINMAX_EN
            s1_a     <= '0;
            s1_b     <= '0;
`endif
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_c_lo  <= c_lo;
                s1_eq_lo <= eq_lo;
                s1_a_hi  <= in_src1[WIDTH-1:SPLIT];
                s1_b_hi  <= in_src2[WIDTH-1:SPLIT];
                s1_op    <= cmp_op_e'(in_op);
                s1_tag   <= in_tag;
`ifdef CMP_MINMAX_EN
                s1_a     <= in_src1;
                s1_b     <= in_src2;
`endif
            end
        end
    end

    cmp_slice #(.W(HI_W)) u_hi (
        .a    (s1_a_hi),
        .b    (s1_b_hi),
        .cin  (s1_c_lo),
        .cout (c_hi),
        .eq   (eq_hi)
    );

    assign sign_a = s1_a_hi[HI_W-1];
    assign sign_b = s1_b_hi[HI_W-1];
    assign eq     = s1_eq_lo & eq_hi;
    assign lt_u   = ~c_hi;
    // With matching signs the difference cannot overflow, so sum[W-1] is exactly ~cout.
    assign lt_s   = (sign_a & ~sign_b) | (~(sign_a ^ sign_b) & ~c_hi);

    always_comb begin
        res_nxt = 1'b0;
        case (s1_op)
            CMP_EQ:  res_nxt = eq;
            CMP_NE:  res_nxt = ~eq;
            CMP_LT:  res_nxt = lt_s;
            CMP_GE:  res_nxt = ~lt_s;
            CMP_LTU: res_nxt = lt_u;
            CMP_GEU: res_nxt = ~lt_u;
`ifdef CMP_MINMAX_EN
            CMP_MIN, CMP_MAX: res_nxt = lt_s;
`endif
            default: res_nxt = 1'b0;
        endcase
    end

`ifdef CMP_MINMAX_EN
    always_comb begin
        sel_nxt = '0;
        if (s1_op == CMP_MIN)      sel_nxt = lt_s ? s1_a : s1_b;
        else if (s1_op == CMP_MAX) sel_nxt = lt_s ? s1_b : s1_a;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_res   <= 1'b0;
            out_tag   <= '0;
`ifdef CMP_MINMAX_EN
            out_sel   <= '0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= res_nxt;
                out_tag <= s1_tag;
`ifdef CMP_MINMAX_EN
                out_sel <= sel_nxt;
`endif
            end
        end
    end

endmodule
